// File: rtl/move_input_controller_pkg.sv
// Shared types and constants for the move input controller slice.
package move_input_controller_pkg;

  localparam int unsigned NUM_COLS = 4;

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_CHECK        = 2'd1,
    ST_ISSUE        = 2'd2,
    ST_WAIT_RELEASE = 2'd3
  } state_e;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_SWITCH   = 2'b01;
  localparam logic [1:0] ERR_FULL     = 2'b10;
  localparam logic [1:0] ERR_INACTIVE = 2'b11;

  function automatic logic sw_onehot(input logic [NUM_COLS-1:0] v);
    return (v != '0) && ((v & (v - 1'b1)) == '0);
  endfunction

  function automatic logic [1:0] sw_encode(input logic [NUM_COLS-1:0] v);
    logic [1:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < NUM_COLS; i++) begin
      if (v[i]) idx = i[1:0];
    end
    return idx;
  endfunction

endpackage

// File: rtl/move_input_controller_debouncer.sv
// Two-flop synchronizer, stability counter and rising-edge detect for the drop button.
module button_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_i,
  output logic level_o,
  output logic press_o
);

  logic       sync1_q, sync2_q;
  logic       deb_q, deb_d;
  logic       prev_q;
  logic [7:0] cnt_q, cnt_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      deb_q   <= 1'b0;
      prev_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      prev_q  <= deb_q;
      cnt_q   <= cnt_d;
    end
  end

  // The count must have reached DEBOUNCE_CYCLES before the level flips.
  always_comb begin
    cnt_d = '0;
    deb_d = deb_q;
    if (sync2_q != deb_q) begin
      if (cnt_q == 8'(DEBOUNCE_CYCLES)) begin
        deb_d = ~deb_q;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end
  end

  always_comb begin
    level_o = deb_q;
    press_o = deb_q & ~prev_q;
  end

endmodule

// File: rtl/move_input_controller.sv
// Validates debounced drop presses and issues one column move per press over valid/ready.
module move_input_controller
  import move_input_controller_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned ROWS            = 4,
  parameter int unsigned CNT_W           = 3
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      btn,
  input  logic [NUM_COLS-1:0]       col_sw,
  input  logic [NUM_COLS*CNT_W-1:0] col_fill,
  input  logic                      game_active,
  input  logic                      move_ready,
  output logic                      move_valid,
  output logic [1:0]                move_col,
  output logic                      reject,
  output logic [1:0]                err_code,
  output logic                      busy
);

  localparam logic [CNT_W:0] ROWS_W = (CNT_W + 1)'(ROWS);

  state_e           state_q, state_d;
  logic [1:0]       move_col_q, move_col_d;
  logic [1:0]       err_q, err_d;
  logic             reject_q, reject_d;
  logic             level, press;
  logic [1:0]       sel_idx;
  logic [CNT_W-1:0] sel_fill;

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debouncer (
    .clk_i  (clk),
    .rst_ni (reset),
    .btn_i  (btn),
    .level_o(level),
    .press_o(press)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      move_col_q <= '0;
      err_q      <= ERR_NONE;
      reject_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      move_col_q <= move_col_d;
      err_q      <= err_d;
      reject_q   <= reject_d;
    end
  end

  always_comb begin
    sel_idx  = sw_encode(col_sw);
    sel_fill = '0;
    for (int unsigned i = 0; i < NUM_COLS; i++) begin
      if (sel_idx == i[1:0]) sel_fill = col_fill[i*CNT_W +: CNT_W];
    end
  end

  always_comb begin
    state_d    = state_q;
    move_col_d = move_col_q;
    err_d      = err_q;
    reject_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (press) begin
          if (game_active) begin
            state_d = ST_CHECK;
            err_d   = ERR_NONE;
          end else begin
            state_d  = ST_WAIT_RELEASE;
            err_d    = ERR_INACTIVE;
            reject_d = 1'b1;
          end
        end
      end
      ST_CHECK: begin
        if (!sw_onehot(col_sw)) begin
          state_d  = ST_WAIT_RELEASE;
          err_d    = ERR_SWITCH;
          reject_d = 1'b1;
        end else if ({1'b0, sel_fill} >= ROWS_W) begin
          state_d  = ST_WAIT_RELEASE;
          err_d    = ERR_FULL;
          reject_d = 1'b1;
        end else begin
          state_d    = ST_ISSUE;
          move_col_d = sel_idx;
        end
      end
      // A completed transfer wins over a same-cycle drop of game_active.
      ST_ISSUE: begin
        if (move_ready) begin
          state_d = ST_WAIT_RELEASE;
        end else if (!game_active) begin
          state_d  = ST_WAIT_RELEASE;
          err_d    = ERR_INACTIVE;
          reject_d = 1'b1;
        end
      end
      ST_WAIT_RELEASE: begin
        if (!level) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    move_valid = (state_q == ST_ISSUE);
    busy       = (state_q != ST_IDLE);
    move_col   = move_col_q;
    reject     = reject_q;
    err_code   = err_q;
  end

endmodule
